// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RISC-V-lite pipeline.
// Issues requests on a req/gnt/rvalid data-memory port, generates byte
// enables and replicated store data, aligns and extends load data, stalls
// the pipeline while an access is outstanding and registers MEM/WB values.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently masking the offset to natural alignment.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_en,
  input  logic [6:0]  cwMEM,
  input  logic [31:0] ALUres,
  input  logic [31:0] Bout,
  input  logic [31:0] Rdest,
  input  logic [31:0] NPC4_IN,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic [31:0] LMD,
  output logic [31:0] ALUout_WB,
  output logic [31:0] NPC4_WB,
  output logic [31:0] Rdest_WB,
  output logic [1:0]  cwWB
);

  localparam int N = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // Byte offset masked to the natural alignment of the access size.
  function automatic logic [1:0] nat_offset(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  // Byte-lane enables for a (naturally aligned) offset.
  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the enabled lane carries it.
  function automatic logic [N-1:0] gen_wdata(input logic [1:0] size, input logic [N-1:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend.
  function automatic logic [N-1:0] load_align(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [N-1:0] rd);
    logic [N-1:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'b00:   return uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // Half needs addr[0]=0, word (and size 11) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction
`endif

  state_e state_q, state_d;

  // Decode of the incoming control word. A read wins over a write.
  logic [1:0] size_s, off_s;
  logic       access_s, load_s, store_s, misalign_s, issue_s;

  assign size_s   = cwMEM[4:3];
  assign access_s = cwMEM[6] | cwMEM[5];
  assign load_s   = cwMEM[6];
  assign store_s  = cwMEM[5] & ~cwMEM[6];
  assign off_s    = nat_offset(size_s, ALUres[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_s = access_s & is_misaligned(size_s, ALUres[1:0]);
`else
  assign misalign_s = 1'b0;
`endif
  assign issue_s  = access_s & ~misalign_s;

  logic [N-1:0] addr_in_s, wdata_in_s;
  logic [3:0]   be_in_s;

  assign addr_in_s  = {ALUres[N-1:2], 2'b00};
  assign be_in_s    = gen_be(size_s, off_s);
  assign wdata_in_s = gen_wdata(size_s, Bout);

  // Access attributes and instruction payload captured when a request issues.
  logic         we_q, uns_q;
  logic [N-1:0] addr_q, wdata_q, alu_q, npc4_q, rdest_q;
  logic [3:0]   be_q;
  logic [1:0]   size_q, off_q, cwwb_q;
  logic         issue_en_s;

  assign issue_en_s = (state_q == S_IDLE) & issue_s;

  // Capture the request and instruction payload at issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      npc4_q  <= '0;
      rdest_q <= '0;
      be_q    <= 4'b0000;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      cwwb_q  <= 2'b00;
    end else if (issue_en_s) begin
      we_q    <= store_s;
      uns_q   <= cwMEM[2];
      addr_q  <= addr_in_s;
      wdata_q <= wdata_in_s;
      alu_q   <= ALUres;
      npc4_q  <= NPC4_IN;
      rdest_q <= Rdest;
      be_q    <= be_in_s;
      size_q  <= size_s;
      off_q   <= off_s;
      cwwb_q  <= cwMEM[1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue_s) begin
          if (dmem_gnt) begin
            state_d = load_s ? S_WAIT : S_IDLE;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          state_d = we_q ? S_IDLE : S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic wb_sel_latch_s, load_done_s;

  // FSM outputs: memory port, stall and write-back source selection.
  always_comb begin
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_be        = 4'b0000;
    dmem_wdata     = '0;
    mem_stall      = 1'b0;
    wb_sel_latch_s = 1'b0;
    load_done_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue_s) begin
          dmem_req   = 1'b1;
          dmem_we    = store_s;
          dmem_addr  = addr_in_s;
          dmem_be    = be_in_s;
          dmem_wdata = wdata_in_s;
          mem_stall  = ~(store_s & dmem_gnt);
        end else begin
          mem_stall  = 1'b0;
        end
      end
      S_REQ: begin
        dmem_req       = 1'b1;
        dmem_we        = we_q;
        dmem_addr      = addr_q;
        dmem_be        = be_q;
        dmem_wdata     = wdata_q;
        mem_stall      = ~(we_q & dmem_gnt);
        wb_sel_latch_s = 1'b1;
      end
      S_WAIT: begin
        mem_stall      = ~dmem_rvalid;
        load_done_s    = dmem_rvalid;
        wb_sel_latch_s = 1'b1;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

  // MEM/WB next values: latched payload once an access has issued.
  logic         wb_en_s;
  logic [N-1:0] lmd_d, alu_wb_d, npc4_wb_d, rdest_wb_d;
  logic [1:0]   cwwb_wb_d;

  assign wb_en_s    = pipe_en & ~mem_stall;
  assign lmd_d      = load_done_s ? load_align(size_q, uns_q, off_q, dmem_rdata) : '0;
  assign alu_wb_d   = wb_sel_latch_s ? alu_q   : ALUres;
  assign npc4_wb_d  = wb_sel_latch_s ? npc4_q  : NPC4_IN;
  assign rdest_wb_d = wb_sel_latch_s ? rdest_q : Rdest;
  assign cwwb_wb_d  = wb_sel_latch_s ? cwwb_q  : {cwMEM[1] & ~misalign_s, cwMEM[0]};

  logic [N-1:0] lmd_q, alu_wb_q, npc4_wb_q, rdest_wb_q;
  logic [1:0]   cwwb_wb_q;

  // MEM/WB pipeline register, advanced when the stage is not stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lmd_q      <= '0;
      alu_wb_q   <= '0;
      npc4_wb_q  <= '0;
      rdest_wb_q <= '0;
      cwwb_wb_q  <= 2'b00;
    end else if (wb_en_s) begin
      lmd_q      <= lmd_d;
      alu_wb_q   <= alu_wb_d;
      npc4_wb_q  <= npc4_wb_d;
      rdest_wb_q <= rdest_wb_d;
      cwwb_wb_q  <= cwwb_wb_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_wb_q;

  // Misalignment flag travels with its instruction into MEM/WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_wb_q <= 1'b0;
    end else if (wb_en_s) begin
      mis_wb_q <= misalign_s & ~wb_sel_latch_s;
    end
  end

  assign misalign_err = mis_wb_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign LMD       = lmd_q;
  assign ALUout_WB = alu_wb_q;
  assign NPC4_WB   = npc4_wb_q;
  assign Rdest_WB  = rdest_wb_q;
  assign cwWB      = cwwb_wb_q;

endmodule
